round_judge: RTL

- Sits directly upstream of the per-player score counters in the TicTacToe design.
- After every move it evaluates the 3x3 board snapshot by scanning the 8 winning lines sequentially, one line per clock.
- On a result it emits a single-cycle increment pulse for the winning player (wired to that player's score counter `increment`) or a draw pulse, then holds a round-over state until a new round is requested.

---
 rtl/round_judge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/round_judge.sv
// round_judge: evaluates a TicTacToe board snapshot after each move by scanning
// the 8 winning lines one per clock, then emits a single-cycle score increment
// for the winner (or a draw pulse) and holds round-over until a new round.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   board[17:0]  cell i (row-major 0..8) at bits [2i+1:2i], sampled on accepted check
//   check        request to evaluate board (accepted only in IDLE)
//   new_round    clears the result / aborts a scan, returns to IDLE
//   busy         scan in progress
//   inc_x/inc_o  one-cycle win pulse for X / O (score counter increment)
//   draw         one-cycle pulse, full board with no line
//   round_over   level, from result pulse until new_round
//   winner[1:0]  CELL_X / CELL_O of the winner, 2'b00 otherwise
//   win_line[2:0] index of the winning line, 0 when no win
module round_judge #(
    parameter logic [1:0] CELL_X = 2'b01,
    parameter logic [1:0] CELL_O = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [17:0] board,
    input  logic        check,
    input  logic        new_round,
    output logic        busy,
    output logic        inc_x,
    output logic        inc_o,
    output logic        draw,
    output logic        round_over,
    output logic [1:0]  winner,
    output logic [2:0]  win_line
);

    localparam int unsigned CELLS   = 9;
    localparam int unsigned CELL_W  = 2;
    localparam int unsigned BOARD_W = CELLS * CELL_W;
    localparam int unsigned LINE_W  = 3;
    localparam int unsigned IDX_W   = 4;
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(7);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, OVER} state_t;

    state_t              state, state_d;
    logic [BOARD_W-1:0]  snap, snap_d;
    logic [LINE_W-1:0]   idx, idx_d;
    logic                busy_d, inc_x_d, inc_o_d, draw_d, round_over_d;
    logic [1:0]          winner_d;
    logic [LINE_W-1:0]   win_line_d;

    logic [IDX_W-1:0]    ca, cb, cc;
    logic [1:0]          va, vb, vc;
    logic                line_hit, board_full;

    // Cell indices of each line; index order is also the win priority.
    always_comb begin
        ca = '0; cb = '0; cc = '0;
        unique case (idx)
            3'd0: begin ca = 4'd0; cb = 4'd1; cc = 4'd2; end
            3'd1: begin ca = 4'd3; cb = 4'd4; cc = 4'd5; end
            3'd2: begin ca = 4'd6; cb = 4'd7; cc = 4'd8; end
            3'd3: begin ca = 4'd0; cb = 4'd3; cc = 4'd6; end
            3'd4: begin ca = 4'd1; cb = 4'd4; cc = 4'd7; end
            3'd5: begin ca = 4'd2; cb = 4'd5; cc = 4'd8; end
            3'd6: begin ca = 4'd0; cb = 4'd4; cc = 4'd8; end
            3'd7: begin ca = 4'd2; cb = 4'd4; cc = 4'd6; end
            default: ;
        endcase
    end

    // Line match on the snapshot; 2'b11 is not a mark so it never matches.
    always_comb begin
        va = snap[{ca, 1'b0} +: CELL_W];
        vb = snap[{cb, 1'b0} +: CELL_W];
        vc = snap[{cc, 1'b0} +: CELL_W];
        line_hit = (va == vb) && (vb == vc) && ((va == CELL_X) || (va == CELL_O));
    end

    // Board full only when every cell holds a real mark.
    always_comb begin
        board_full = 1'b1;
        for (int i = 0; i < int'(CELLS); i++) begin
            if ((snap[CELL_W*i +: CELL_W] != CELL_X) && (snap[CELL_W*i +: CELL_W] != CELL_O))
                board_full = 1'b0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snap       <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            inc_x      <= 1'b0;
            inc_o      <= 1'b0;
            draw       <= 1'b0;
            round_over <= 1'b0;
            winner     <= 2'b00;
            win_line   <= '0;
        end else begin
            state      <= state_d;
            snap       <= snap_d;
            idx        <= idx_d;
            busy       <= busy_d;
            inc_x      <= inc_x_d;
            inc_o      <= inc_o_d;
            draw       <= draw_d;
            round_over <= round_over_d;
            winner     <= winner_d;
            win_line   <= win_line_d;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_d      = state;
        snap_d       = snap;
        idx_d        = idx;
        busy_d       = busy;
        inc_x_d      = 1'b0;
        inc_o_d      = 1'b0;
        draw_d       = 1'b0;
        round_over_d = round_over;
        winner_d     = winner;
        win_line_d   = win_line;

        if (new_round) begin
            // Abort or clear from any state; a pending result is dropped.
            state_d      = IDLE;
            idx_d        = '0;
            busy_d       = 1'b0;
            round_over_d = 1'b0;
            winner_d     = 2'b00;
            win_line_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (check) begin
                        snap_d  = board;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    if (line_hit) begin
                        winner_d   = va;
                        win_line_d = idx;
                        state_d    = REPORT;
                    end else if (idx != LAST_LINE) begin
                        idx_d = idx + LINE_W'(1);
                    end else if (board_full) begin
                        // Draw is signalled by reaching REPORT with winner still 00.
                        state_d = REPORT;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                REPORT: begin
                    inc_x_d      = (winner == CELL_X);
                    inc_o_d      = (winner == CELL_O);
                    draw_d       = (winner == 2'b00);
                    round_over_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = OVER;
                end
                OVER: ;
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
